// File: rtl/cla_pkg.sv
// Shared types for the 4-bit carry-lookahead slice: PG vector width and the
// bundled result of the lookahead equations.
package cla_pkg;
  localparam int CLA_WIDTH = 4;

  typedef logic [CLA_WIDTH-1:0] pg_vec_t;

  typedef struct packed {
    logic c1;
    logic c2;
    logic c3;
    logic c4;
    logic g;
    logic p;
  } cla_res_t;
endpackage

// File: rtl/cla_lookahead_core.sv
// Two-level sum-of-products lookahead equations; no ripple path from cin to C4.
module cla_lookahead_core
  import cla_pkg::*;
(
  input  pg_vec_t  g,
  input  pg_vec_t  p,
  input  logic     cin,
  output cla_res_t res
);

  // Group generate is the C4 expression with the cin term removed, so it can be
  // cascaded into a second-level lookahead tier.
  logic grp_g;

  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  assign res.c1 = g[0]
                | (p[0] & cin);
  assign res.c2 = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
  assign res.c3 = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
  assign res.c4 = grp_g
                | (p[3] & p[2] & p[1] & p[0] & cin);
  assign res.g  = grp_g;
  assign res.p  = p[3] & p[2] & p[1] & p[0];

endmodule

// File: rtl/cla_lookahead_unit.sv
// 4-bit carry-lookahead generator with an optional registered output stage
// (one cycle of latency) cleared by an asynchronous active-low reset.
module cla_lookahead_unit
  import cla_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic g0,
  input  logic p0,
  input  logic g1,
  input  logic p1,
  input  logic g2,
  input  logic p2,
  input  logic g3,
  input  logic p3,
  input  logic cin,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4,
  output logic G,
  output logic P
);

  pg_vec_t  g_p0;
  pg_vec_t  p_p0;
  cla_res_t res_p0;
  cla_res_t res_out;

  assign g_p0 = {g3, g2, g1, g0};
  assign p_p0 = {p3, p2, p1, p0};

  cla_lookahead_core u_core (
    .g   (g_p0),
    .p   (p_p0),
    .cin (cin),
    .res (res_p0)
  );

  // Stage p0 -> p1: output register, cleared immediately when rst_n drops.
  generate
    if (REG_OUT) begin : g_reg
      cla_res_t res_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_p1 <= '0;
        end else begin
          res_p1 <= res_p0;
        end
      end

      assign res_out = res_p1;
    end else begin : g_comb
      assign res_out = res_p0;
    end
  endgenerate

  assign C1 = res_out.c1;
  assign C2 = res_out.c2;
  assign C3 = res_out.c3;
  assign C4 = res_out.c4;
  assign G  = res_out.g;
  assign P  = res_out.p;

endmodule

// File: tb/tb_cla_lookahead_unit.sv
// Self-checking bench for cla_lookahead_unit: registered and combinational
// instances compared against a ripple-carry reference model.
module tb_cla_lookahead_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] g, p;
  logic       cin;

  logic rC1, rC2, rC3, rC4, rG, rP;
  logic cC1, cC2, cC3, cC4, cG, cP;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_lookahead_unit #(.REG_OUT(1'b1)) u_reg (
    .clk (clk), .rst_n (rst_n),
    .g0 (g[0]), .p0 (p[0]), .g1 (g[1]), .p1 (p[1]),
    .g2 (g[2]), .p2 (p[2]), .g3 (g[3]), .p3 (p[3]),
    .cin (cin),
    .C1 (rC1), .C2 (rC2), .C3 (rC3), .C4 (rC4), .G (rG), .P (rP)
  );

  cla_lookahead_unit #(.REG_OUT(1'b0)) u_comb (
    .clk (clk), .rst_n (rst_n),
    .g0 (g[0]), .p0 (p[0]), .g1 (g[1]), .p1 (p[1]),
    .g2 (g[2]), .p2 (p[2]), .g3 (g[3]), .p3 (p[3]),
    .cin (cin),
    .C1 (cC1), .C2 (cC2), .C3 (cC3), .C4 (cC4), .G (cG), .P (cP)
  );

  wire [5:0] reg_out  = {rC1, rC2, rC3, rC4, rG, rP};
  wire [5:0] comb_out = {cC1, cC2, cC3, cC4, cG, cP};

  // Reference: plain ripple carry; group generate is the carry-out with cin=0.
  function automatic logic [5:0] ref_model(input logic [3:0] gv, input logic [3:0] pv,
                                           input logic ci);
    logic [4:0] c;
    logic [4:0] c0;
    c[0]  = ci;
    c0[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c[i+1]  = gv[i] | (pv[i] & c[i]);
      c0[i+1] = gv[i] | (pv[i] & c0[i]);
    end
    return {c[1], c[2], c[3], c[4], c0[4], &pv};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got C1C2C3C4GP=%b expected %b (g=%b p=%b cin=%b) t=%0t",
               name, act, exp, g, p, cin, $time);
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [3:0] p;
    logic       cin;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [5:0] prev_exp;

    vecs[0] = '{"mixed_gp",     4'b1101, 4'b1010, 1'b0, 6'b111110};
    vecs[1] = '{"full_prop_c1", 4'b0000, 4'b1111, 1'b1, 6'b111101};
    vecs[2] = '{"full_prop_c0", 4'b0000, 4'b1111, 1'b0, 6'b000001};
    vecs[3] = '{"broken_chain", 4'b0000, 4'b0111, 1'b1, 6'b111000};
    vecs[4] = '{"gp_both_one",  4'b1111, 4'b1111, 1'b0, 6'b111111};
    vecs[5] = '{"all_zero",     4'b0000, 4'b0000, 1'b1, 6'b000000};

    // Reset held with inputs toggling: outputs must stay 0, including before any edge.
    rst_n = 1'b0;
    g = 4'b1111; p = 4'b1111; cin = 1'b1;
    #1 check("reset_no_edge", reg_out, 6'b000000);
    for (int i = 0; i < 4; i++) begin
      g = 4'($urandom); p = 4'($urandom); cin = 1'($urandom);
      #7 check("reset_hold", reg_out, 6'b000000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    g = 4'b1111; p = 4'b1111; cin = 1'b1;
    @(posedge clk); #1;
    check("reset_release", reg_out, 6'b111111);

    // Table vectors, each held for a second cycle to confirm it is stable.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = vecs[i].g; p = vecs[i].p; cin = vecs[i].cin;
      #1 check({vecs[i].name, "_comb"}, comb_out, vecs[i].exp);
      @(posedge clk); #1;
      check(vecs[i].name, reg_out, vecs[i].exp);
      @(posedge clk); #1;
      check({vecs[i].name, "_hold"}, reg_out, vecs[i].exp);
    end

    // Latency: change inputs between edges; registered output waits for next edge.
    @(negedge clk);
    g = 4'b0000; p = 4'b1111; cin = 1'b1;
    @(posedge clk); #1;
    prev_exp = ref_model(g, p, cin);
    g = 4'b0000; p = 4'b0000; cin = 1'b0;
    #1;
    check("latency_reg_old", reg_out, prev_exp);
    check("latency_comb_new", comb_out, ref_model(g, p, cin));
    @(posedge clk); #1;
    check("latency_reg_new", reg_out, ref_model(g, p, cin));

    // Async reset mid-cycle: outputs drop at once, in-flight result discarded.
    @(negedge clk);
    g = 4'b1111; p = 4'b1111; cin = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check("async_reset_mid", reg_out, 6'b000000);
    check("comb_ignores_reset", comb_out, 6'b111111);
    @(posedge clk); #1;
    check("async_reset_edge", reg_out, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep of {g,p,cin} with a reset pulse partway through.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      {g, p, cin} = 9'(i);
      #1 check("sweep_comb", comb_out, ref_model(g, p, cin));
      @(posedge clk); #1;
      check("sweep_reg", reg_out, ref_model(g, p, cin));
      if (i == 200) begin
        rst_n = 1'b0;
        #1 check("sweep_reset", reg_out, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Random back-to-back stream: a new result every cycle.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      g = 4'($urandom); p = 4'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check("random_reg", reg_out, ref_model(g, p, cin));
      check("random_comb", comb_out, ref_model(g, p, cin));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
